// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill path.
//   refill_state_e : refill controller state encoding (IDLE/REQ/FILL/WRITE)
//   DEF_*_WIDTH    : default address, line and memory-beat widths
//   LINE_OFF_W     : byte-offset bits inside a default-width cache line
//   line_off_bits  : byte-offset bits for an arbitrary line width
package icache_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 64;
  localparam int unsigned DEF_BLOCK_WIDTH = 512;
  localparam int unsigned DEF_BEAT_WIDTH  = 32;
  localparam int unsigned LINE_OFF_W      = $clog2(DEF_BLOCK_WIDTH / 8);

  // Explicit encodings keep the state register readable in waveforms.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FILL  = 2'd2,
    ST_WRITE = 2'd3
  } refill_state_e;

  function automatic int unsigned line_off_bits(input int unsigned block_width);
    return $clog2(block_width / 8);
  endfunction

endpackage

// File: rtl/icache_beat_assembler.sv
// Collects memory response beats into one cache line.
//   i_clk, i_arst_n : clock, asynchronous active-low reset
//   i_clear         : restart at beat 0 (asserted as the burst request is accepted)
//   i_beat_valid    : write i_beat_data into the current slot and advance
//   i_beat_data     : one response beat
//   o_last          : current slot is the final beat of the line
//   o_block         : registered line buffer, beat 0 in the lowest bits
module icache_beat_assembler
  import icache_pkg::*;
#(
  parameter int unsigned BLOCK_WIDTH = DEF_BLOCK_WIDTH,
  parameter int unsigned BEAT_WIDTH  = DEF_BEAT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_clear,
  input  logic                   i_beat_valid,
  input  logic [BEAT_WIDTH-1:0]  i_beat_data,
  output logic                   o_last,
  output logic [BLOCK_WIDTH-1:0] o_block
);

  localparam int unsigned BEAT_COUNT = BLOCK_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_W      = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;

  logic [CNT_W-1:0]       r_cnt;
  logic [BLOCK_WIDTH-1:0] r_block;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_beat_valid) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Slot decode per beat keeps the write enables explicit for synthesis.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_block <= '0;
    end else if (i_beat_valid && !i_clear) begin
      for (int k = 0; k < BEAT_COUNT; k++) begin
        if (r_cnt == CNT_W'(k)) begin
          r_block[k*BEAT_WIDTH +: BEAT_WIDTH] <= i_beat_data;
        end
      end
    end
  end

  assign o_last  = (r_cnt == CNT_W'(BEAT_COUNT - 1));
  assign o_block = r_block;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: latches the miss address, issues one
// line-aligned burst read, assembles the returned beats into a line and
// writes it into the cache for a single cycle. o_busy stalls fetch meanwhile.
//   i_clk, i_arst_n                       : clock, asynchronous active-low reset
//   i_miss, i_miss_addr                   : fetch miss and its address
//   o_busy                                : refill in progress
//   o_mem_req_valid/i_mem_req_ready/_addr : burst read request channel
//   i_mem_rsp_valid/o_mem_rsp_ready/_data : response beat channel
//   o_cache_we/_addr/_block               : cache write port
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned BLOCK_WIDTH = DEF_BLOCK_WIDTH,
  parameter int unsigned BEAT_WIDTH  = DEF_BEAT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_miss,
  input  logic [ADDR_WIDTH-1:0]  i_miss_addr,
  output logic                   o_busy,
  output logic                   o_mem_req_valid,
  input  logic                   i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
  input  logic                   i_mem_rsp_valid,
  output logic                   o_mem_rsp_ready,
  input  logic [BEAT_WIDTH-1:0]  i_mem_rsp_data,
  output logic                   o_cache_we,
  output logic [ADDR_WIDTH-1:0]  o_cache_addr,
  output logic [BLOCK_WIDTH-1:0] o_cache_block
);

  localparam int unsigned LINE_OFF = line_off_bits(BLOCK_WIDTH);

  if (BLOCK_WIDTH % BEAT_WIDTH != 0) begin : g_bad_width
    $error("BLOCK_WIDTH must be an integer multiple of BEAT_WIDTH");
  end

  refill_state_e         r_state;
  refill_state_e         w_state_d;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_req_fire;
  logic                  w_beat_fire;
  logic                  w_last;

  assign w_req_fire  = (r_state == ST_REQ) && i_mem_req_ready;
  assign w_beat_fire = (r_state == ST_FILL) && i_mem_rsp_valid;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      ST_IDLE:  if (i_miss) w_state_d = ST_REQ;
      ST_REQ:   if (w_req_fire) w_state_d = ST_FILL;
      ST_FILL:  if (w_beat_fire && w_last) w_state_d = ST_WRITE;
      ST_WRITE: w_state_d = ST_IDLE;
      default:  w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Address is only captured from IDLE, so it stays put for the whole refill.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_addr <= '0;
    end else if ((r_state == ST_IDLE) && i_miss) begin
      r_addr <= i_miss_addr;
    end
  end

  icache_beat_assembler #(
    .BLOCK_WIDTH (BLOCK_WIDTH),
    .BEAT_WIDTH  (BEAT_WIDTH)
  ) u_beat_assembler (
    .i_clk        (i_clk),
    .i_arst_n     (i_arst_n),
    .i_clear      (w_req_fire),
    .i_beat_valid (w_beat_fire),
    .i_beat_data  (i_mem_rsp_data),
    .o_last       (w_last),
    .o_block      (o_cache_block)
  );

  // All outputs are decodes of registered state: nothing combinational from inputs.
  assign o_busy          = (r_state != ST_IDLE);
  assign o_mem_req_valid = (r_state == ST_REQ);
  assign o_mem_rsp_ready = (r_state == ST_FILL);
  assign o_cache_we      = (r_state == ST_WRITE);
  assign o_mem_req_addr  = {r_addr[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
  assign o_cache_addr    = r_addr;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;

  logic         i_clk;
  logic         i_arst_n;
  logic         i_miss;
  logic [63:0]  i_miss_addr;
  logic         o_busy;
  logic         o_mem_req_valid;
  logic         i_mem_req_ready;
  logic [63:0]  o_mem_req_addr;
  logic         i_mem_rsp_valid;
  logic         o_mem_rsp_ready;
  logic [31:0]  i_mem_rsp_data;
  logic         o_cache_we;
  logic [63:0]  o_cache_addr;
  logic [511:0] o_cache_block;

  int checks = 0;
  int errors = 0;

  icache_refill_ctrl dut (
    .i_clk           (i_clk),
    .i_arst_n        (i_arst_n),
    .i_miss          (i_miss),
    .i_miss_addr     (i_miss_addr),
    .o_busy          (o_busy),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_req_addr  (o_mem_req_addr),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .o_mem_rsp_ready (o_mem_rsp_ready),
    .i_mem_rsp_data  (i_mem_rsp_data),
    .o_cache_we      (o_cache_we),
    .o_cache_addr    (o_cache_addr),
    .o_cache_block   (o_cache_block)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One complete refill starting in an IDLE cycle; returns in the first IDLE
  // cycle afterwards so consecutive calls form back-to-back misses.
  // gaps[k] inserts one invalid cycle before beat k.
  task automatic do_refill(input logic [63:0] addr, input int req_wait,
                           input logic [15:0] gaps, input bit rnd_data,
                           input bit spur, input logic [63:0] exp_req, input int exp_lat);
    logic [511:0] exp_blk;
    logic [31:0]  beat;
    int           cyc;
    int           n;
    exp_blk = '0;
    cyc = 0;
    chk("idle_busy", o_busy, 1'b0);
    i_miss = 1'b1;
    i_miss_addr = addr;
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = spur;
    i_mem_rsp_data = $urandom;
    if (spur) chk("idle_rsp_ready", o_mem_rsp_ready, 1'b0);
    tick(); cyc++;
    i_miss = spur;
    i_miss_addr = {$urandom, $urandom};
    for (int w = 0; w <= req_wait; w++) begin
      chk("req_valid", o_mem_req_valid, 1'b1);
      chk("req_addr", o_mem_req_addr, exp_req);
      chk("req_rsp_ready", o_mem_rsp_ready, 1'b0);
      chk("req_we", o_cache_we, 1'b0);
      i_mem_req_ready = (w == req_wait);
      tick(); cyc++;
    end
    i_mem_req_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (gaps[k]) begin
        chk("fill_ready_gap", o_mem_rsp_ready, 1'b1);
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data = $urandom;
        tick(); cyc++;
      end
      chk("fill_ready", o_mem_rsp_ready, 1'b1);
      chk("fill_req_valid", o_mem_req_valid, 1'b0);
      chk("fill_we", o_cache_we, 1'b0);
      beat = rnd_data ? 32'($urandom) : 32'(k);
      exp_blk[k*32 +: 32] = beat;
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data = beat;
      tick(); cyc++;
    end
    i_mem_rsp_valid = spur;
    i_mem_rsp_data = $urandom;
    i_miss = 1'b0;
    n = 0;
    while (!o_cache_we && n < 4) begin
      tick(); cyc++; n++;
    end
    chk("write_cycle", 32'(cyc), 32'(exp_lat));
    chk("write_we", o_cache_we, 1'b1);
    chk("write_busy", o_busy, 1'b1);
    chk("write_rsp_ready", o_mem_rsp_ready, 1'b0);
    chk("write_addr", o_cache_addr, addr);
    chk("write_block", o_cache_block, exp_blk);
    tick();
    chk("after_we", o_cache_we, 1'b0);
    chk("after_busy", o_busy, 1'b0);
    i_mem_rsp_valid = 1'b0;
  endtask

  typedef struct {
    logic [63:0] addr;
    int          req_wait;
    logic [15:0] gaps;
    bit          rnd_data;
    bit          spur;
    logic [63:0] exp_req;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [63:0] a;
    logic [15:0] g;
    int          w;
    vecs[0] = '{64'h0000_0000_0000_1234, 0, 16'h0000, 1'b0, 1'b0, 64'h0000_0000_0000_1200, 18};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 5, 16'hAAAA, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 31};
    vecs[2] = '{64'h0000_0000_0000_003F, 0, 16'h0000, 1'b1, 1'b1, 64'h0000_0000_0000_0000, 18};
    vecs[3] = '{64'h8000_0000_0000_0040, 2, 16'h8001, 1'b1, 1'b1, 64'h8000_0000_0000_0040, 22};
    vecs[4] = '{64'hDEAD_BEEF_0000_00FF, 1, 16'hFFFF, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_00C0, 35};

    // Reset held with a pending miss: everything quiet.
    i_arst_n = 1'b0;
    i_miss = 1'b1;
    i_miss_addr = 64'h0000_0000_0000_1234;
    i_mem_req_ready = 1'b1;
    i_mem_rsp_valid = 1'b1;
    i_mem_rsp_data = 32'hFFFF_FFFF;
    repeat (3) tick();
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_req_valid", o_mem_req_valid, 1'b0);
    chk("rst_rsp_ready", o_mem_rsp_ready, 1'b0);
    chk("rst_we", o_cache_we, 1'b0);
    chk("rst_cache_addr", o_cache_addr, 64'h0);
    chk("rst_block", o_cache_block, 512'h0);
    i_arst_n = 1'b1;

    // Table vectors, all back-to-back (next miss in first IDLE after WRITE).
    for (int i = 0; i < 5; i++) begin
      do_refill(vecs[i].addr, vecs[i].req_wait, vecs[i].gaps, vecs[i].rnd_data,
                vecs[i].spur, vecs[i].exp_req, vecs[i].exp_lat);
    end

    // Reset in the middle of FILL after 7 beats.
    i_miss = 1'b1;
    i_miss_addr = 64'h0000_0000_0000_5000;
    tick();
    i_miss = 1'b0;
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data = 32'hA5A5_0000 + 32'(k);
      tick();
    end
    chk("midfill_ready", o_mem_rsp_ready, 1'b1);
    #2;
    i_arst_n = 1'b0;
    #1;
    chk("midrst_busy", o_busy, 1'b0);
    chk("midrst_rsp_ready", o_mem_rsp_ready, 1'b0);
    chk("midrst_req_valid", o_mem_req_valid, 1'b0);
    chk("midrst_we", o_cache_we, 1'b0);
    chk("midrst_block", o_cache_block, 512'h0);
    tick();
    i_mem_rsp_valid = 1'b0;
    i_arst_n = 1'b1;
    do_refill(64'h0000_0000_0000_5004, 0, 16'h0000, 1'b1, 1'b0, 64'h0000_0000_0000_5000, 18);

    // Randomized refills checked against arithmetic expectations.
    for (int r = 0; r < 25; r++) begin
      a = {$urandom, $urandom};
      w = int'($urandom_range(0, 4));
      g = 16'($urandom);
      do_refill(a, w, g, 1'b1, 1'($urandom), a & ~64'h3F, 18 + w + $countones(g));
      repeat ($urandom_range(0, 2)) begin
        chk("idle_gap_busy", o_busy, 1'b0);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss-handling stage directly upstream of the direct-mapped instruction cache.
- On a fetch miss, captures the address, issues one block-aligned burst read to the memory side, and assembles BEAT_WIDTH response beats into a BLOCK_WIDTH line.
- Then drives the cache write port for exactly one cycle.
- Asserts busy to stall fetch for the whole refill.

Parameters:
- ADDR_WIDTH, 64, fetch/memory address width.
- BLOCK_WIDTH, 512, cache line width in bits.
- BEAT_WIDTH, 32, memory response data width; BLOCK_WIDTH must be an integer multiple of it.
- BEAT_COUNT, BLOCK_WIDTH/BEAT_WIDTH (16), beats per line; derived, not overridden.

Ports:
- i_clk  in  1  clock.
- i_arst_n  in  1  asynchronous active-low reset.
- i_miss  in  1  fetch valid AND cache o_hit low.
- i_miss_addr  in  ADDR_WIDTH  fetch address of the miss.
- o_busy  out  1  refill in progress; stalls fetch.
- o_mem_req_valid  out  1  burst read request valid.
- i_mem_req_ready  in  1  memory accepts request.
- o_mem_req_addr  out  ADDR_WIDTH  line-aligned request address.
- i_mem_rsp_valid  in  1  response beat valid.
- o_mem_rsp_ready  out  1  controller accepts beat.
- i_mem_rsp_data  in  BEAT_WIDTH  response beat.
- o_cache_we  out  1  cache write enable.
- o_cache_addr  out  ADDR_WIDTH  captured miss address (cache derives tag/index from it).
- o_cache_block  out  BLOCK_WIDTH  assembled line.

Behaviour:
- Reset (async, i_arst_n low): state IDLE; beat counter 0; address register 0; line buffer 0. Outputs o_busy, o_mem_req_valid, o_mem_rsp_ready, o_cache_we all 0. Reset mid-refill abandons the burst immediately; late beats are not accepted because o_mem_rsp_ready is 0.
- States: IDLE, REQ, FILL, WRITE. o_busy = (state != IDLE), registered-state decode.
- IDLE: if i_miss=1, latch i_miss_addr, go to REQ. Otherwise stay.
- REQ: o_mem_req_valid=1. o_mem_req_addr = latched address with the low log2(BLOCK_WIDTH/8) bits (6) zeroed. Address is held stable until the handshake completes. When valid&ready, clear the beat counter and go to FILL.
- FILL: o_mem_rsp_ready=1. Each cycle with i_mem_rsp_valid, write the beat into line bits [cnt*BEAT_WIDTH +: BEAT_WIDTH] (beat 0 = lowest address = lowest bits) and increment cnt. On the beat where cnt=BEAT_COUNT-1, go to WRITE. Gaps in valid simply stall.
- WRITE: o_cache_we=1 for exactly one cycle, with o_cache_addr and o_cache_block stable. Next state IDLE.
- o_cache_addr and o_cache_block are driven from registers at all times. Only o_cache_we qualifies them.
- i_miss is ignored in REQ, FILL and WRITE. A new i_miss in the first IDLE cycle after WRITE starts a new refill; in normal flow the cache hits there instead.
- i_mem_rsp_valid outside FILL is ignored (ready=0); no state change.
- Beat counter width is $clog2(BEAT_COUNT). Wrap to 0 happens only on transition into FILL.
- Latency with zero-wait memory: miss at cycle 0 → REQ at 1 → FILL at 2 → beats at 2..17 → WRITE at 18 → cache hit at 19.
- One outstanding burst only; no critical-word-first, no error response.

Decomposition:
- Shared package icache_pkg: state enum typedef (IDLE/REQ/FILL/WRITE), default ADDR/BLOCK/BEAT widths, line-offset width constant.
- One natural sub-module, icache_beat_assembler: beat counter plus indexed line-buffer write, with "last beat" output. The FSM stays in icache_refill_ctrl.

Test Plan:
- Reset: hold i_arst_n=0 with i_miss=1 → all outputs 0, state IDLE. Release → REQ on the next edge.
- Basic refill: i_miss_addr=0x0000_0000_0000_1234, ready=1, 16 back-to-back beats data=k → o_mem_req_addr=0x1200. At cycle 18: o_cache_we=1 for one cycle, o_cache_block[k*32+:32]=k, o_cache_addr=0x1234.
- Backpressure: i_mem_req_ready low for 5 cycles → o_mem_req_valid and address stable throughout. Beats with alternating valid gaps → WRITE is delayed accordingly and all 16 beats land in the correct slots.
- Spurious input: i_mem_rsp_valid=1 in IDLE/REQ and i_miss=1 during FILL → o_mem_rsp_ready=0, no extra request, beat count unaffected.
- Reset mid-FILL after 7 beats → outputs 0 immediately. A subsequent miss refills cleanly with no residue of the old beats in the slots written.
- Back-to-back misses: second miss in the first IDLE cycle after WRITE → new REQ the following cycle with the new aligned address.
